// File: rtl/txd_frame_rx.sv
// txd_frame_rx: receive-side sink for a byte transmit interface (txd/tx_en).
//
// Rebuilds frames from contiguous tx_en runs and drops runts (< MIN_LEN bytes),
// giants (> MAX_LEN bytes) and frames that do not fit in the FIFO. Good frames
// go into a commit/rollback FIFO. They are released downstream on a valid/ready
// byte stream with an end-of-frame flag.
//
// Optional build macro: TXD_RX_STATS_EN adds saturating frame_cnt / drop_cnt.
//
// Ports:
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   txd, tx_en        incoming bytes; one frame = one contiguous run of tx_en=1
//   m_data, m_last    FIFO head byte and its end-of-frame flag
//   m_valid, m_ready  downstream handshake; a byte moves when both are high
//   frame_drop        one-cycle pulse for each discarded frame
//   drop_cause        01 runt, 10 giant, 11 overflow; holds until the next drop
//   frame_cnt         good frames committed (TXD_RX_STATS_EN only)
//   drop_cnt          frames dropped (TXD_RX_STATS_EN only)
module txd_frame_rx #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned MAX_LEN = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_drop,
  output logic [1:0]  drop_cause
`ifdef TXD_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [PW-1:0] PtrOne = PW'(1);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_spec_q, wr_spec_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [7:0]      stage_q, stage_d;
  logic [8:0]      mem_q [DEPTH];
  logic            frame_drop_q;
  logic [1:0]      drop_cause_q;

  logic            push;
  logic [8:0]      push_data;
  logic            commit;
  logic            rollback;
  logic [1:0]      cause;
  logic            full;

  // Write-side occupancy counts speculative bytes of the frame being received.
  assign full    = ((wr_spec_q - rd_ptr_q) == PW'(DEPTH));
  // Only committed entries are visible downstream.
  assign m_valid = (wr_commit_q != rd_ptr_q);
  assign {m_last, m_data} = m_valid ? mem_q[rd_ptr_q[IW-1:0]] : 9'h000;

  assign frame_drop = frame_drop_q;
  assign drop_cause = drop_cause_q;

  always_comb begin
    state_d     = state_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    len_d       = len_q;
    stage_d     = stage_q;
    push        = 1'b0;
    push_data   = {1'b0, stage_q};
    commit      = 1'b0;
    rollback    = 1'b0;
    cause       = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (tx_en) begin
          stage_d = txd;
          len_d   = LW'(1);
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (tx_en) begin
          if (len_q == LW'(MAX_LEN)) begin
            rollback = 1'b1;
            cause    = 2'b10;
            state_d  = StDrop;
          end else if (full) begin
            rollback = 1'b1;
            cause    = 2'b11;
            state_d  = StDrop;
          end else begin
            // The staged byte is not the last one; new byte takes its place.
            push      = 1'b1;
            wr_spec_d = wr_spec_q + PtrOne;
            stage_d   = txd;
            len_d     = len_q + LW'(1);
          end
        end else begin
          state_d = StIdle;
          if (len_q < LW'(MIN_LEN)) begin
            rollback = 1'b1;
            cause    = 2'b01;
          end else if (full) begin
            rollback = 1'b1;
            cause    = 2'b11;
          end else begin
            push        = 1'b1;
            push_data   = {1'b1, stage_q};
            commit      = 1'b1;
            wr_spec_d   = wr_spec_q + PtrOne;
            wr_commit_d = wr_spec_q + PtrOne;
          end
        end
      end
      StDrop: begin
        if (!tx_en) state_d = StIdle;
      end
      default: state_d = StDrop;
    endcase

    if (rollback) wr_spec_d = wr_commit_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (m_valid && m_ready) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StDrop;
      wr_spec_q    <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      stage_q      <= '0;
      frame_drop_q <= 1'b0;
      drop_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wr_spec_q    <= wr_spec_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      stage_q      <= stage_d;
      frame_drop_q <= rollback;
      if (rollback) drop_cause_q <= cause;
    end
  end

  // Storage needs no reset: nothing is visible until pointers say so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_spec_q[IW-1:0]] <= push_data;
  end

`ifdef TXD_RX_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (commit && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (rollback && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_txd_frame_rx.sv
// Testbench for txd_frame_rx: directed scenarios plus randomized frames and
// randomized m_ready, checked by a scoreboard against a frame-level model.
module tb_txd_frame_rx;

  localparam int DEPTH   = 16;
  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        tx_en = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        frame_drop;
  logic [1:0]  drop_cause;
`ifdef TXD_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  txd_frame_rx #(
    .DEPTH   (DEPTH),
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .txd        (txd),
    .tx_en      (tx_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_drop (frame_drop),
    .drop_cause (drop_cause)
`ifdef TXD_RX_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected output bytes {last,data} and expected drop causes.
  logic [8:0] expq[$];
  logic [1:0] dropq[$];

  // Model state.
  logic [7:0] cur[$];
  bit         m_busy = 1'b0;
  bit         m_ignoring = 1'b1;
  int         unread = 0;
  int         model_frames = 0;
  int         model_drops = 0;

  int         rdy_mode = 0;
  logic [7:0] frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: decides each frame's fate from its length and
  // the FIFO space left by committed-but-unread bytes.
  initial begin
    bit rd;
    int used;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur.delete();
        m_busy = 1'b0;
        m_ignoring = 1'b1;
        unread = 0;
        model_frames = 0;
        model_drops = 0;
        expq.delete();
        dropq.delete();
      end else begin
        rd = m_ready && (unread > 0);
        used = unread + (m_busy ? cur.size() - 1 : 0);
        if (m_ignoring) begin
          if (!tx_en) m_ignoring = 1'b0;
        end else if (!m_busy) begin
          if (tx_en) begin
            cur.delete();
            cur.push_back(txd);
            m_busy = 1'b1;
          end
        end else if (tx_en) begin
          if (cur.size() == MAX_LEN || used == DEPTH) begin
            dropq.push_back((cur.size() == MAX_LEN) ? 2'b10 : 2'b11);
            model_drops++;
            m_busy = 1'b0;
            m_ignoring = 1'b1;
          end else begin
            cur.push_back(txd);
          end
        end else begin
          m_busy = 1'b0;
          if (cur.size() < MIN_LEN || used == DEPTH) begin
            dropq.push_back((cur.size() < MIN_LEN) ? 2'b01 : 2'b11);
            model_drops++;
          end else begin
            for (int i = 0; i < cur.size(); i++)
              expq.push_back({(i == cur.size() - 1) ? 1'b1 : 1'b0, cur[i]});
            unread += cur.size();
            model_frames++;
          end
        end
        if (rd) unread--;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on the falling edge.
  initial begin
    bit         stall_prev;
    logic [8:0] held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_valid", {31'd0, m_valid}, {31'd0, unread > 0});
        if (stall_prev)
          check("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, held});
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte: got %0h, expected no byte at %0t", {m_last, m_data}, $time);
          end else begin
            check("byte", {23'd0, m_last, m_data}, {23'd0, expq.pop_front()});
          end
        end
        check("frame_drop", {31'd0, frame_drop}, {31'd0, dropq.size() > 0});
        if (frame_drop && dropq.size() > 0)
          check("drop_cause", {30'd0, drop_cause}, {30'd0, dropq.pop_front()});
        stall_prev = m_valid && !m_ready;
        held = {m_last, m_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // m_ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        2:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      txd = frame_q[i];
      tx_en = 1'b1;
      tick();
    end
    tx_en = 1'b0;
    txd = 8'($urandom);
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while (expq.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    tick();
    check("drain", expq.size(), 0);
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_last", {31'd0, m_last}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_frame_drop", {31'd0, frame_drop}, 0);
    check("rst_drop_cause", {30'd0, drop_cause}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Basic 4-byte frame.
    rdy_mode = 1;
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(2);
    drain();
`ifdef TXD_RX_STATS_EN
    check("frame_cnt_1", {16'd0, frame_cnt}, 1);
`endif

    // Runt.
    frame_q = '{8'hAA};
    send_frame(2);
    drain();
`ifdef TXD_RX_STATS_EN
    check("drop_cnt_1", {16'd0, drop_cnt}, 1);
`endif

    // Giant followed by a good frame after a single-cycle gap.
    frame_q.delete();
    for (int i = 0; i < 13; i++) frame_q.push_back(8'(8'h80 + i));
    send_frame(1);
    frame_q = '{8'h01, 8'h02, 8'h03};
    send_frame(2);
    drain();

    // Fill the FIFO with the consumer stalled; the fifth frame overflows.
    rdy_mode = 0;
    tick();
    for (int f = 0; f < 5; f++) begin
      frame_q.delete();
      for (int j = 0; j < 4; j++) frame_q.push_back(8'(f * 16 + j));
      send_frame(1);
    end
    tick();
    check("fill_unread", unread, DEPTH);
    rdy_mode = 1;
    drain();

    // Reset during the third byte, released while tx_en is still high.
    frame_q = '{8'h61, 8'h62};
    send_frame(0);
    txd = 8'h63;
    tx_en = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txd = 8'(8'h64 + i);
      tx_en = 1'b1;
      tick();
    end
    tx_en = 1'b0;
    tick();
    frame_q = '{8'h5A, 8'hA5};
    send_frame(2);
    drain();

    // Back-to-back 3-byte frames with m_ready toggling every cycle.
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      frame_q = '{8'(8'hC0 + f * 3), 8'(8'hC1 + f * 3), 8'(8'hC2 + f * 3)};
      send_frame(1);
    end
    check("toggle_no_drop", dropq.size(), 0);
    rdy_mode = 1;
    drain();

    // Randomized frames, gaps and back-pressure.
    rdy_mode = 3;
    for (int f = 0; f < 150; f++) begin
      frame_q.delete();
      for (int j = 0; j < $urandom_range(1, MAX_LEN + 2); j++) frame_q.push_back(8'($urandom));
      send_frame($urandom_range(1, 3));
    end
    rdy_mode = 1;
    drain();

    check("dropq_empty", dropq.size(), 0);
`ifdef TXD_RX_STATS_EN
    check("frame_cnt_end", {16'd0, frame_cnt}, model_frames);
    check("drop_cnt_end", {16'd0, drop_cnt}, model_drops);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
